// File: rtl/fft_pkg.sv
// Shared FFT definitions: sample width, default OMEM address width and the
// output-reader state encoding.
package fft_pkg;

    localparam int DATA_W    = 32;
    localparam int N_DEFAULT = 4;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        LD,
        S0,
        S1
    } reader_state_t;

endpackage

// File: rtl/fft_omem_reader_if.sv
// Bundle of the reader's FFT-core, OMEM and streaming signals. The master side
// is the reader; the slave side is the FFT core / OMEM / downstream sink.
interface fft_omem_reader_if #(
    parameter int N = fft_pkg::N_DEFAULT
);
    import fft_pkg::*;

    logic              out_vld;
    logic              out_rdy;
    logic [N-1:0]      addr0_OMEM;
    logic [N-1:0]      addr1_OMEM;
    logic [DATA_W-1:0] data0_rd_OMEM;
    logic [DATA_W-1:0] data1_rd_OMEM;
    logic [DATA_W-1:0] m_data;
    logic              m_vld;
    logic              m_rdy;
    logic              m_last;

    modport master (
        input  out_vld, data0_rd_OMEM, data1_rd_OMEM, m_rdy,
        output out_rdy, addr0_OMEM, addr1_OMEM, m_data, m_vld, m_last
    );

    modport slave (
        output out_vld, data0_rd_OMEM, data1_rd_OMEM, m_rdy,
        input  out_rdy, addr0_OMEM, addr1_OMEM, m_data, m_vld, m_last
    );

endinterface

// File: rtl/fft_omem_reader_bitrev.sv
// Combinational W-bit bit reversal, used to turn a bit-reversed OMEM index
// into natural frequency order.
module bit_reverse #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_in,
    output logic [W-1:0] o_out
);

    always_comb begin
        o_out = '0;
        for (int i = 0; i < W; i++) begin
            o_out[i] = i_in[W-1-i];
        end
    end

endmodule

// File: rtl/fft_omem_reader.sv
// Streams a finished FFT frame out of dual-port OMEM, two samples per read.
// Define FFT_OUT_BITREV_EN to read OMEM in bit-reversed address order.
module fft_omem_reader
    import fft_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic               clk,
    input  logic               rstn,
    fft_omem_reader_if.master  bus
);

    localparam logic [N-2:0] P_LAST = '1;
    localparam logic [N-2:0] P_ONE  = (N-1)'(1);

    reader_state_t     r_state;
    reader_state_t     w_state_nxt;
    logic [N-2:0]      r_p;
    logic [N-2:0]      w_p_nxt;
    logic [DATA_W-1:0] r_buf0;
    logic [DATA_W-1:0] r_buf1;
    logic [N-1:0]      r_addr0;
    logic [N-1:0]      r_addr1;
    logic [N-1:0]      w_k0;
    logic [N-1:0]      w_k1;
    logic [N-1:0]      w_map0;
    logic [N-1:0]      w_map1;
    logic              w_out_rdy;
    logic              w_m_vld;
    logic              w_m_last;
    logic [DATA_W-1:0] w_m_data;

    // Sample indices of the pair about to be read, taken from the next pair count.
    assign w_k0 = {w_p_nxt, 1'b0};
    assign w_k1 = {w_p_nxt, 1'b1};

`ifdef FFT_OUT_BITREV_EN
    bit_reverse #(.W(N)) u_rev0 (.i_in(w_k0), .o_out(w_map0));
    bit_reverse #(.W(N)) u_rev1 (.i_in(w_k1), .o_out(w_map1));
`else
    assign w_map0 = w_k0;
    assign w_map1 = w_k1;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_p_nxt     = r_p;
        w_out_rdy   = 1'b0;
        w_m_vld     = 1'b0;
        w_m_last    = 1'b0;
        w_m_data    = '0;
        case (r_state)
            IDLE: begin
                w_out_rdy = 1'b1;
                if (bus.out_vld) begin
                    w_state_nxt = RD;
                    w_p_nxt     = '0;
                end
            end
            RD: w_state_nxt = LD;
            LD: w_state_nxt = S0;
            S0: begin
                w_m_vld  = 1'b1;
                w_m_data = r_buf0;
                if (bus.m_rdy) begin
                    w_state_nxt = S1;
                end
            end
            S1: begin
                w_m_vld  = 1'b1;
                w_m_data = r_buf1;
                w_m_last = (r_p == P_LAST);
                if (bus.m_rdy) begin
                    if (r_p == P_LAST) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_p_nxt     = r_p + P_ONE;
                        w_state_nxt = RD;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Addresses are registered on entry to RD so OMEM sees them for the whole RD cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_p     <= '0;
            r_buf0  <= '0;
            r_buf1  <= '0;
            r_addr0 <= '0;
            r_addr1 <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_p     <= w_p_nxt;
            if (w_state_nxt == RD) begin
                r_addr0 <= w_map0;
                r_addr1 <= w_map1;
            end
            if (r_state == LD) begin
                r_buf0 <= bus.data0_rd_OMEM;
                r_buf1 <= bus.data1_rd_OMEM;
            end
        end
    end

    assign bus.out_rdy    = w_out_rdy;
    assign bus.m_vld      = w_m_vld;
    assign bus.m_last     = w_m_last;
    assign bus.m_data     = w_m_data;
    assign bus.addr0_OMEM = r_addr0;
    assign bus.addr1_OMEM = r_addr1;

endmodule

// File: tb/tb_fft_omem_reader.sv
// Self-checking bench for fft_omem_reader: directed order/latency/reset
// scenarios plus randomized backpressure against a frame-order model.
module tb_fft_omem_reader;
    import fft_pkg::*;

    localparam int N     = N_DEFAULT;
    localparam int FRAME = 1 << N;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    fft_omem_reader_if #(.N(N)) bus ();

    fft_omem_reader #(.N(N)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    logic [31:0] mem [FRAME];

    // Synchronous-read OMEM model: data appears one cycle after its address.
    always @(posedge clk) begin
        bus.data0_rd_OMEM <= mem[bus.addr0_OMEM];
        bus.data1_rd_OMEM <= mem[bus.addr1_OMEM];
    end

    int tests = 0;
    int fails = 0;
    logic [31:0] obs_data[$];
    logic        obs_last[$];

    function automatic int map_idx(int k);
        int r;
        r = k;
`ifdef FFT_OUT_BITREV_EN
        r = 0;
        for (int b = 0; b < N; b++) begin
            if ((k & (1 << b)) != 0) r = r | (1 << (N - 1 - b));
        end
`endif
        return r;
    endfunction

    // Sample s of a stream of back-to-back frames
    function automatic logic [31:0] expected_sample(int s);
        return mem[map_idx(s % FRAME)];
    endfunction

    task automatic fill_mem(input bit random_fill);
        for (int k = 0; k < FRAME; k++) mem[k] = random_fill ? $urandom : 32'(k);
    endtask

    task automatic start_frame;
        @(negedge clk);
        bus.out_vld = 1'b1;
        @(posedge clk);
        #1 bus.out_vld = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.out_rdy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Collects accepted beats; m_rdy is decided at each negedge for the coming edge.
    task automatic collect(input int nsamples, input int rdy_pct, input int stall_idx,
                           input int stall_len, output int busy, output int stab_err,
                           output bit timeout);
        int          stall_left;
        int          cyc;
        logic        prev_hold;
        logic [31:0] held_d;
        logic        held_l;
        stall_left = stall_len;
        cyc        = 0;
        prev_hold  = 1'b0;
        held_d     = '0;
        held_l     = 1'b0;
        busy       = 0;
        stab_err   = 0;
        timeout    = 1'b0;
        obs_data.delete();
        obs_last.delete();
        while (obs_data.size() < nsamples) begin
            @(negedge clk);
            cyc++;
            if (cyc > 3000) begin
                timeout = 1'b1;
                break;
            end
            if (!bus.out_rdy) busy++;
            if (prev_hold && (bus.m_vld !== 1'b1 || bus.m_data !== held_d || bus.m_last !== held_l))
                stab_err++;
            if (bus.m_vld && stall_left > 0 && obs_data.size() == stall_idx) begin
                bus.m_rdy = 1'b0;
                stall_left--;
            end else begin
                bus.m_rdy = ($urandom_range(99) < rdy_pct);
            end
            if (bus.m_vld && bus.m_rdy) begin
                obs_data.push_back(bus.m_data);
                obs_last.push_back(bus.m_last);
            end
            prev_hold = bus.m_vld && !bus.m_rdy;
            held_d    = bus.m_data;
            held_l    = bus.m_last;
        end
    endtask

    task automatic test_reset;
        bus.out_vld = 1'b0;
        bus.m_rdy   = 1'b0;
        rstn        = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (bus.out_rdy !== 1'b1) begin fails++; $display("[TB] FAIL reset_out_rdy: got %b expected 1", bus.out_rdy); end
        tests++; if (bus.m_vld !== 1'b0) begin fails++; $display("[TB] FAIL reset_m_vld: got %b expected 0", bus.m_vld); end
        tests++; if (bus.m_last !== 1'b0) begin fails++; $display("[TB] FAIL reset_m_last: got %b expected 0", bus.m_last); end
        tests++; if (bus.m_data !== 32'h0) begin fails++; $display("[TB] FAIL reset_m_data: got %h expected 0", bus.m_data); end
        tests++; if (bus.addr0_OMEM !== '0) begin fails++; $display("[TB] FAIL reset_addr0: got %h expected 0", bus.addr0_OMEM); end
        tests++; if (bus.addr1_OMEM !== '0) begin fails++; $display("[TB] FAIL reset_addr1: got %h expected 0", bus.addr1_OMEM); end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_stream_order;
        int busy, stab, ref_v;
        bit to, ok;
        int bitrev_ref[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
        fill_mem(1'b0);
        bus.m_rdy = 1'b1;
        start_frame();
        collect(FRAME, 100, -1, 0, busy, stab, to);
        wait_idle(ok);
        if (ok) busy++;
        tests++; if (to || !ok) begin fails++; $display("[TB] FAIL order_timeout: got timeout=%0b idle=%0b expected 0/1", to, ok); end
        for (int i = 0; i < obs_data.size(); i++) begin
`ifdef FFT_OUT_BITREV_EN
            ref_v = bitrev_ref[i];
`else
            ref_v = i;
`endif
            tests++; if (obs_data[i] !== 32'(ref_v)) begin fails++; $display("[TB] FAIL order_data[%0d]: got %0d expected %0d", i, obs_data[i], ref_v); end
            tests++; if (obs_last[i] !== (i == FRAME - 1)) begin fails++; $display("[TB] FAIL order_last[%0d]: got %b expected %b", i, obs_last[i], (i == FRAME - 1)); end
        end
        // busy counts the cycles out of IDLE plus the first IDLE cycle seen afterwards
        tests++; if (busy !== 2 * FRAME + 1) begin fails++; $display("[TB] FAIL order_frame_cycles: got %0d expected %0d", busy - 1, 2 * FRAME); end
    endtask

    task automatic test_backpressure;
        int busy, stab;
        bit to, ok;
        fill_mem(1'b0);
        bus.m_rdy = 1'b1;
        start_frame();
        collect(FRAME, 100, 3, 5, busy, stab, to);
        wait_idle(ok);
        tests++; if (to || !ok) begin fails++; $display("[TB] FAIL bp_timeout: got timeout=%0b idle=%0b expected 0/1", to, ok); end
        tests++; if (stab !== 0) begin fails++; $display("[TB] FAIL bp_stable: got %0d changes expected 0", stab); end
        tests++; if (busy !== 2 * FRAME + 5) begin fails++; $display("[TB] FAIL bp_cycles: got %0d expected %0d", busy, 2 * FRAME + 5); end
        for (int i = 0; i < obs_data.size(); i++) begin
            tests++; if (obs_data[i] !== expected_sample(i)) begin fails++; $display("[TB] FAIL bp_data[%0d]: got %h expected %h", i, obs_data[i], expected_sample(i)); end
        end
    endtask

    task automatic test_latency_handshake;
        int          c;
        int          acc[$];
        int          vld_cyc;
        logic        rdy_after;
        logic [31:0] d[$];
        logic        l[$];
        bit          ok;
        c         = 0;
        vld_cyc   = -1;
        rdy_after = 1'bx;
        fill_mem(1'b1);
        @(negedge clk);
        bus.m_rdy   = 1'b1;
        bus.out_vld = 1'b1;
        while (acc.size() < 2 && c < 200) begin
            @(negedge clk);
            c++;
            if (acc.size() == 1 && c == acc[0] + 1) rdy_after = bus.out_rdy;
            if (acc.size() >= 1 && vld_cyc < 0 && bus.m_vld) vld_cyc = c;
            if (bus.m_vld && bus.m_rdy) begin
                d.push_back(bus.m_data);
                l.push_back(bus.m_last);
            end
            if (bus.out_vld && bus.out_rdy) acc.push_back(c);
        end
        @(posedge clk);
        #1 bus.out_vld = 1'b0;
        wait_idle(ok);
        tests++; if (acc.size() !== 2 || !ok) begin fails++; $display("[TB] FAIL lat_accepts: got %0d accepts idle=%0b expected 2/1", acc.size(), ok); end
        if (acc.size() == 2) begin
            tests++; if (rdy_after !== 1'b0) begin fails++; $display("[TB] FAIL lat_out_rdy_drop: got %b expected 0", rdy_after); end
            tests++; if (vld_cyc - acc[0] !== 3) begin fails++; $display("[TB] FAIL lat_first_vld: got %0d expected 3", vld_cyc - acc[0]); end
            tests++; if (acc[1] - acc[0] !== 2 * FRAME + 1) begin fails++; $display("[TB] FAIL lat_second_accept: got %0d expected %0d", acc[1] - acc[0], 2 * FRAME + 1); end
        end
        tests++; if (d.size() < FRAME) begin fails++; $display("[TB] FAIL lat_sample_count: got %0d expected >=%0d", d.size(), FRAME); end
        for (int i = 0; i < FRAME && i < d.size(); i++) begin
            tests++; if (d[i] !== expected_sample(i) || l[i] !== (i == FRAME - 1)) begin
                fails++; $display("[TB] FAIL lat_data[%0d]: got %h/%b expected %h/%b", i, d[i], l[i], expected_sample(i), (i == FRAME - 1));
            end
        end
    endtask

    task automatic test_reset_midframe;
        int busy, stab, stray;
        bit to, ok;
        fill_mem(1'b0);
        bus.m_rdy = 1'b1;
        start_frame();
        collect(7, 100, -1, 0, busy, stab, to);
        tests++; if (to) begin fails++; $display("[TB] FAIL rst_pre_timeout: got timeout expected data"); end
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        tests++; if (bus.out_rdy !== 1'b1 || bus.m_vld !== 1'b0 || bus.m_last !== 1'b0) begin
            fails++; $display("[TB] FAIL rst_ctrl: got rdy=%b vld=%b last=%b expected 1/0/0", bus.out_rdy, bus.m_vld, bus.m_last);
        end
        tests++; if (bus.m_data !== 32'h0 || bus.addr0_OMEM !== '0 || bus.addr1_OMEM !== '0) begin
            fails++; $display("[TB] FAIL rst_data: got data=%h a0=%h a1=%h expected 0", bus.m_data, bus.addr0_OMEM, bus.addr1_OMEM);
        end
        repeat (2) @(negedge clk);
        rstn  = 1'b1;
        stray = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.m_vld) stray++;
        end
        tests++; if (stray !== 0) begin fails++; $display("[TB] FAIL rst_no_stray: got %0d valid cycles expected 0", stray); end
        start_frame();
        collect(FRAME, 100, -1, 0, busy, stab, to);
        wait_idle(ok);
        tests++; if (to || !ok) begin fails++; $display("[TB] FAIL rst_restart_timeout: got timeout=%0b idle=%0b expected 0/1", to, ok); end
        for (int i = 0; i < obs_data.size(); i++) begin
            tests++; if (obs_data[i] !== expected_sample(i)) begin fails++; $display("[TB] FAIL rst_restart[%0d]: got %h expected %h", i, obs_data[i], expected_sample(i)); end
        end
    endtask

    task automatic test_random_rdy;
        int busy, stab, nlast;
        bit to, ok;
        fill_mem(1'b1);
        @(negedge clk);
        bus.out_vld = 1'b1;
        collect(3 * FRAME, 50, -1, 0, busy, stab, to);
        bus.out_vld = 1'b0;
        bus.m_rdy   = 1'b1;
        wait_idle(ok);
        tests++; if (to || !ok) begin fails++; $display("[TB] FAIL rand_timeout: got timeout=%0b idle=%0b expected 0/1", to, ok); end
        tests++; if (stab !== 0) begin fails++; $display("[TB] FAIL rand_stable: got %0d changes expected 0", stab); end
        nlast = 0;
        for (int i = 0; i < obs_data.size(); i++) begin
            if (obs_last[i]) nlast++;
            tests++; if (obs_data[i] !== expected_sample(i) || obs_last[i] !== (i % FRAME == FRAME - 1)) begin
                fails++; $display("[TB] FAIL rand_beat[%0d]: got %h/%b expected %h/%b", i, obs_data[i], obs_last[i], expected_sample(i), (i % FRAME == FRAME - 1));
            end
        end
        tests++; if (nlast !== 3) begin fails++; $display("[TB] FAIL rand_last_count: got %0d expected 3", nlast); end
    endtask

    initial begin
        fill_mem(1'b0);
        test_reset();
        test_stream_order();
        test_backpressure();
        test_latency_handshake();
        test_reset_midframe();
        test_random_rdy();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
